perf_count_master: RTL and testbench

Avalon-MM master that drives the four-section performance counter from hardware instead of software. It turns per-section start/stop pulses and a global-clear pulse into the counter's go/stop register writes, and it performs tear-free snapshot reads of a section's 64-bit time count and event count. It sits between custom datapath logic and the counter's control slave, either directly connected or through the system interconnect.

---
 rtl/perf_count_master.sv | 139 +++++++++++++
 tb/tb_perf_count_master.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/perf_count_master.sv
// perf_count_master: Avalon-MM master issuing go/stop/clear writes and tear-free snapshot reads to a 4-section performance counter
module perf_count_master #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [3:0]  avm_address,
  output logic        avm_write,
  output logic        avm_read,
  output logic        avm_begintransfer,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic [3:0]  section_start,
  input  logic [3:0]  section_stop,
  input  logic        clear_req,
  input  logic        snap_req,
  input  logic [1:0]  snap_section,
  output logic        snap_valid,
  output logic [1:0]  snap_id,
  output logic [63:0] snap_time,
  output logic [31:0] snap_events,
  output logic        snap_drop,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, WR, RD, RWAIT, EVAL} state_t;
  localparam logic [2:0] RL = 3'(READ_LATENCY);
  state_t state_q, state_d;
  logic [3:0] addr_q, addr_d, stop_pend_q, stop_pend_d, go_pend_q, go_pend_d, stop_clr, go_clr;
  logic wr_q, wr_d, rd_q, rd_d, bt_q, bt_d, clr_pend_q, clr_pend_d, snap_pend_q, snap_pend_d;
  logic clr_c, take, drop_d, drop_q, valid_q, valid_d, busy_q, busy_d;
  logic [31:0] wdata_q, wdata_d, hi0_q, hi0_d, lo_q, lo_d, hi1_q, hi1_d, ev_q, ev_d, events_q, events_d;
  logic [1:0] snap_sec_q, snap_sec_d, idx_q, idx_d, id_q, id_d;
  logic [2:0] cnt_q, cnt_d;
  logic [63:0] time_q, time_d;
  function automatic logic [1:0] lowest(input logic [3:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
  endfunction
  // word offset of each read in the hi0, lo, hi1, ev sequence
  function automatic logic [1:0] off(input logic [1:0] i);
    return i == 2'd1 ? 2'd0 : i == 2'd3 ? 2'd2 : 2'd1;
  endfunction
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wr_d = wr_q;
    rd_d = rd_q;
    bt_d = 1'b0;
    wdata_d = wdata_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    hi0_d = hi0_q;
    lo_d = lo_q;
    hi1_d = hi1_q;
    ev_d = ev_q;
    time_d = time_q;
    events_d = events_q;
    id_d = id_q;
    valid_d = 1'b0;
    clr_c = 1'b0;
    stop_clr = 4'b0;
    go_clr = 4'b0;
    take = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_pend_q) begin
          state_d = WR; addr_d = 4'd0; wr_d = 1'b1; bt_d = 1'b1; wdata_d = 32'd1;
        end else if (|stop_pend_q) begin
          state_d = WR; addr_d = {lowest(stop_pend_q), 2'b00}; wr_d = 1'b1; bt_d = 1'b1; wdata_d = 32'd0;
        end else if (|go_pend_q) begin
          state_d = WR; addr_d = {lowest(go_pend_q), 2'b01}; wr_d = 1'b1; bt_d = 1'b1; wdata_d = 32'd0;
        end else if (snap_pend_q) begin
          state_d = RD; addr_d = {snap_sec_q, 2'b01}; rd_d = 1'b1; bt_d = 1'b1; idx_d = 2'd0; take = 1'b1;
        end
      end
      WR: if (!avm_waitrequest) begin
        // the completed command is recovered from the address/data still on the bus
        state_d = IDLE; wr_d = 1'b0; wdata_d = 32'd0;
        clr_c = wdata_q[0];
        go_clr = (!wdata_q[0] && addr_q[0]) ? 4'b1 << addr_q[3:2] : 4'b0;
        stop_clr = (!wdata_q[0] && !addr_q[0]) ? 4'b1 << addr_q[3:2] : 4'b0;
      end
      RD: if (!avm_waitrequest) begin
        state_d = RWAIT; rd_d = 1'b0; cnt_d = 3'd1;
      end
      RWAIT: if (cnt_q == RL) begin
        hi0_d = idx_q == 2'd0 ? avm_readdata : hi0_q;
        lo_d = idx_q == 2'd1 ? avm_readdata : lo_q;
        hi1_d = idx_q == 2'd2 ? avm_readdata : hi1_q;
        ev_d = idx_q == 2'd3 ? avm_readdata : ev_q;
        if (idx_q == 2'd3) state_d = EVAL;
        else begin
          state_d = RD; idx_d = idx_q + 2'd1; rd_d = 1'b1; bt_d = 1'b1; addr_d = {snap_sec_q, off(idx_q + 2'd1)};
        end
      end else cnt_d = cnt_q + 3'd1;
      EVAL: if (hi1_q == hi0_q) begin
        state_d = IDLE; time_d = {hi0_q, lo_q}; events_d = ev_q; id_d = snap_sec_q; valid_d = 1'b1;
      end else begin
        // high word moved: adopt it as the new reference and re-read lo
        state_d = RD; hi0_d = hi1_q; idx_d = 2'd1; rd_d = 1'b1; bt_d = 1'b1; addr_d = {snap_sec_q, 2'b00};
      end
      default: state_d = IDLE;
    endcase
  end
  assign clr_pend_d = (clr_pend_q & ~clr_c) | clear_req;
  assign stop_pend_d = (stop_pend_q & ~stop_clr & {4{~clr_c}}) | section_stop;
  assign go_pend_d = (go_pend_q & ~go_clr & {4{~clr_c}}) | section_start;
  assign drop_d = snap_req & (snap_pend_q | (state_q != IDLE && state_q != WR));
  assign snap_pend_d = (snap_pend_q & ~take) | (snap_req & ~drop_d);
  assign snap_sec_d = (snap_req & ~drop_d) ? snap_section : snap_sec_q;
  assign busy_d = clr_pend_d | (|stop_pend_d) | (|go_pend_d) | snap_pend_d | (state_d != IDLE);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q <= '0; wr_q <= 1'b0; rd_q <= 1'b0; bt_q <= 1'b0; wdata_q <= '0;
      clr_pend_q <= 1'b0; stop_pend_q <= '0; go_pend_q <= '0; snap_pend_q <= 1'b0; snap_sec_q <= '0;
      idx_q <= '0; cnt_q <= '0; hi0_q <= '0; lo_q <= '0; hi1_q <= '0; ev_q <= '0;
      time_q <= '0; events_q <= '0; id_q <= '0; valid_q <= 1'b0; drop_q <= 1'b0; busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d; wr_q <= wr_d; rd_q <= rd_d; bt_q <= bt_d; wdata_q <= wdata_d;
      clr_pend_q <= clr_pend_d; stop_pend_q <= stop_pend_d; go_pend_q <= go_pend_d;
      snap_pend_q <= snap_pend_d; snap_sec_q <= snap_sec_d;
      idx_q <= idx_d; cnt_q <= cnt_d; hi0_q <= hi0_d; lo_q <= lo_d; hi1_q <= hi1_d; ev_q <= ev_d;
      time_q <= time_d; events_q <= events_d; id_q <= id_d; valid_q <= valid_d; drop_q <= drop_d; busy_q <= busy_d;
    end
  end
  assign avm_address = addr_q;
  assign avm_write = wr_q;
  assign avm_read = rd_q;
  assign avm_begintransfer = bt_q;
  assign avm_writedata = wdata_q;
  assign snap_valid = valid_q;
  assign snap_id = id_q;
  assign snap_time = time_q;
  assign snap_events = events_q;
  assign snap_drop = drop_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_perf_count_master.sv
// tb_perf_count_master: directed self-checking bench for perf_count_master
module tb_perf_count_master;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [3:0] avm_address;
  logic avm_write, avm_read, avm_begintransfer;
  logic [31:0] avm_writedata, avm_readdata = '0;
  logic avm_waitrequest = 1'b0;
  logic [3:0] section_start = '0, section_stop = '0;
  logic clear_req = 1'b0, snap_req = 1'b0;
  logic [1:0] snap_section = '0;
  logic snap_valid, snap_drop, busy;
  logic [1:0] snap_id;
  logic [63:0] snap_time;
  logic [31:0] snap_events;
  int checks = 0, failures = 0;
  int rn = 0, wcnt = 0, vcnt;
  logic [31:0] rsp [0:31];
  logic [3:0] raddr [0:31];
  perf_count_master #(.READ_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
    .avm_begintransfer(avm_begintransfer), .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .section_start(section_start), .section_stop(section_stop),
    .clear_req(clear_req), .snap_req(snap_req), .snap_section(snap_section), .snap_valid(snap_valid),
    .snap_id(snap_id), .snap_time(snap_time), .snap_events(snap_events), .snap_drop(snap_drop), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (avm_read && !avm_waitrequest) begin
      avm_readdata <= rsp[rn];
      raddr[rn] <= avm_address;
      rn <= rn + 1;
    end
    if (avm_write && !avm_waitrequest) wcnt <= wcnt + 1;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    if (snap_valid) vcnt++;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) rsp[i] = 32'hDEAD_0000 + i;
    rsp[0] = 32'h5; rsp[1] = 32'hFFFF_FFF0; rsp[2] = 32'h5; rsp[3] = 32'h2A;
    rsp[4] = 32'h5; rsp[5] = 32'h3; rsp[6] = 32'h6; rsp[7] = 32'h11;
    rsp[8] = 32'h4; rsp[9] = 32'h6; rsp[10] = 32'h12;
    rsp[11] = 32'h7; rsp[12] = 32'h8; rsp[13] = 32'h7; rsp[14] = 32'h9;
    #1;
    chk("rst_write", avm_write, 0);
    chk("rst_read", avm_read, 0);
    chk("rst_bt", avm_begintransfer, 0);
    chk("rst_busy", busy, 0);
    chk("rst_time", snap_time, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    // go to section 2
    section_start = 4'b0100;
    @(negedge clk); section_start = 4'b0;
    chk("go2_busy", busy, 1);
    chk("go2_idle", avm_write, 0);
    @(negedge clk);
    chk("go2_write", avm_write, 1);
    chk("go2_addr", avm_address, 9);
    chk("go2_data", avm_writedata, 0);
    chk("go2_bt", avm_begintransfer, 1);
    @(negedge clk);
    chk("go2_done", avm_write, 0);
    chk("go2_bt_off", avm_begintransfer, 0);
    chk("go2_busy_off", busy, 0);
    chk("go2_wcnt", wcnt, 1);
    // clear beats simultaneous stops and discards them
    section_stop = 4'b0011; clear_req = 1'b1;
    @(negedge clk); section_stop = 4'b0; clear_req = 1'b0;
    @(negedge clk);
    chk("clr_write", avm_write, 1);
    chk("clr_addr", avm_address, 0);
    chk("clr_data", avm_writedata, 1);
    repeat (8) @(negedge clk);
    chk("clr_wcnt", wcnt, 2);
    chk("clr_busy", busy, 0);
    // go to section 1 stalled by waitrequest for 3 cycles
    section_start = 4'b0010;
    @(negedge clk); section_start = 4'b0; avm_waitrequest = 1'b1;
    @(negedge clk);
    chk("ws_c1_write", avm_write, 1);
    chk("ws_c1_addr", avm_address, 5);
    chk("ws_c1_bt", avm_begintransfer, 1);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("ws_c%0d_write", c), avm_write, 1);
      chk($sformatf("ws_c%0d_addr", c), avm_address, 5);
      chk($sformatf("ws_c%0d_bt", c), avm_begintransfer, 0);
    end
    avm_waitrequest = 1'b0;
    @(negedge clk);
    chk("ws_done", avm_write, 0);
    chk("ws_wcnt", wcnt, 3);
    // snapshot of section 3, exact latency
    snap_req = 1'b1; snap_section = 2'd3;
    @(negedge clk); snap_req = 1'b0;
    repeat (9) @(negedge clk);
    chk("snap3_early", snap_valid, 0);
    @(negedge clk);
    chk("snap3_valid", snap_valid, 1);
    chk("snap3_time", snap_time, 64'h5_FFFF_FFF0);
    chk("snap3_ev", snap_events, 32'h2A);
    chk("snap3_id", snap_id, 3);
    chk("snap3_a0", raddr[0], 13);
    chk("snap3_a1", raddr[1], 12);
    chk("snap3_a2", raddr[2], 13);
    chk("snap3_a3", raddr[3], 14);
    @(negedge clk);
    chk("snap3_pulse", snap_valid, 0);
    // torn snapshot of section 0
    snap_req = 1'b1; snap_section = 2'd0;
    @(negedge clk); snap_req = 1'b0;
    for (int i = 0; i < 60 && !snap_valid; i++) @(negedge clk);
    chk("tear_valid", snap_valid, 1);
    chk("tear_time", snap_time, 64'h6_0000_0004);
    chk("tear_ev", snap_events, 32'h12);
    chk("tear_id", snap_id, 0);
    chk("tear_reads", rn, 11);
    chk("tear_relo", raddr[8], 0);
    chk("tear_rehi", raddr[9], 1);
    // second snap_req while active is dropped
    vcnt = 0;
    snap_req = 1'b1; snap_section = 2'd2;
    step(); snap_req = 1'b0;
    step(); step(); step();
    snap_req = 1'b1; snap_section = 2'd1;
    step(); snap_req = 1'b0;
    chk("drop_pulse", snap_drop, 1);
    step();
    chk("drop_once", snap_drop, 0);
    repeat (40) step();
    chk("drop_vcnt", vcnt, 1);
    chk("drop_id", snap_id, 2);
    chk("drop_time", snap_time, 64'h7_0000_0008);
    // reset in the middle of a read
    snap_req = 1'b1; snap_section = 2'd1;
    @(negedge clk); snap_req = 1'b0;
    @(negedge clk);
    chk("rr_read_on", avm_read, 1);
    reset_n = 1'b0;
    #1;
    chk("rr_read", avm_read, 0);
    chk("rr_addr", avm_address, 0);
    chk("rr_bt", avm_begintransfer, 0);
    chk("rr_busy", busy, 0);
    chk("rr_time", snap_time, 0);
    chk("rr_id", snap_id, 0);
    @(negedge clk); reset_n = 1'b1;
    vcnt = 0;
    repeat (20) step();
    chk("rr_novalid", vcnt, 0);
    chk("rr_idle", avm_read, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
